mem_responder: RTL and testbench

- Single-outstanding memory responder on the slave side of the req/gnt/rvalid data port that the multi-port arbiter drives.
- Accepts one request at a time and commits writes with byte enables into an internal word-addressed array.
- Returns read data, or a write acknowledge, after a fixed programmable latency, echoing the request id.
- Acts as the default on-chip scratchpad/endpoint behind the arbiter, and as the bench model for it.

---
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding scratchpad responder for the arbiter data port.
// Accepts one request, commits writes at grant, responds after LATENCY cycles.
module mem_responder #(
  parameter int NR_PORTS   = 3,
  parameter int DATA_WIDTH = 64,
  parameter int NR_WORDS   = 256,
  parameter int LATENCY    = 1,
  parameter int IDW        = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  input  logic [63:0]             address_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [1:0]              data_size_i,
  input  logic [IDW-1:0]          id_i,
  output logic                    data_gnt_o,
  output logic [IDW-1:0]          gnt_id_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [IDW-1:0]          id_o
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW  = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [IDW-1:0]        id_p0;
  logic                  we_p0;
  logic [IW-1:0]         idx_p0;
  logic [DATA_WIDTH-1:0] rdata_p1;

  logic [DATA_WIDTH-1:0] mem [NR_WORDS];

  logic [IW-1:0]         idx;
  logic                  gnt;

  // Access size and out-of-range address bits carry no meaning here.
  logic                  unused_bits;
  assign unused_bits = ^{data_size_i, address_i};

  assign idx = address_i[OFF +: IW];
  assign gnt = (state == IDLE) && data_req_i && !rst_i;

  assign data_gnt_o    = gnt;
  assign gnt_id_o      = gnt ? id_i : '0;
  assign data_rvalid_o = (state == RESP) && !rst_i;
  assign id_o          = data_rvalid_o ? id_p0 : '0;
  assign data_rdata_o  = (data_rvalid_o && !we_p0) ? rdata_p1 : '0;

  // Stage p0: capture request and commit write data at the grant edge.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (data_be_i[k]) begin
          mem[idx][k*8 +: 8] <= data_wdata_i[k*8 +: 8];
        end
      end
    end
  end

  // Stage p1: count down the latency and load read data on entry to RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      id_p0    <= '0;
      we_p0    <= 1'b0;
      idx_p0   <= '0;
      rdata_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt) begin
            id_p0  <= id_i;
            we_p0  <= data_we_i;
            idx_p0 <= idx;
            cnt    <= 4'(LATENCY - 1);
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              // Reads never write the array, so the pre-edge value is current.
              rdata_p1 <= mem[idx];
              state    <= RESP;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rdata_p1 <= mem[idx_p0];
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=1, one at LATENCY=4.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // LATENCY=1 instance signals
  logic        a_req, a_we;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_be;
  logic [1:0]  a_size, a_id;
  logic        a_gnt, a_rvalid;
  logic [1:0]  a_gnt_id, a_id_o;
  logic [63:0] a_rdata;

  // LATENCY=4 instance signals
  logic        b_req, b_we;
  logic [63:0] b_addr, b_wdata;
  logic [7:0]  b_be;
  logic [1:0]  b_size, b_id;
  logic        b_gnt, b_rvalid;
  logic [1:0]  b_gnt_id, b_id_o;
  logic [63:0] b_rdata;

  mem_responder #(.NR_PORTS(3), .DATA_WIDTH(64), .NR_WORDS(256), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .data_req_i(a_req), .address_i(a_addr),
    .data_wdata_i(a_wdata), .data_we_i(a_we), .data_be_i(a_be), .data_size_i(a_size),
    .id_i(a_id), .data_gnt_o(a_gnt), .gnt_id_o(a_gnt_id), .data_rvalid_o(a_rvalid),
    .data_rdata_o(a_rdata), .id_o(a_id_o)
  );

  mem_responder #(.NR_PORTS(3), .DATA_WIDTH(64), .NR_WORDS(256), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .data_req_i(b_req), .address_i(b_addr),
    .data_wdata_i(b_wdata), .data_we_i(b_we), .data_be_i(b_be), .data_size_i(b_size),
    .id_i(b_id), .data_gnt_o(b_gnt), .gnt_id_o(b_gnt_id), .data_rvalid_o(b_rvalid),
    .data_rdata_o(b_rdata), .id_o(b_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  id;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [9];

  logic [63:0] port_addr [3];
  logic [63:0] port_exp  [3];
  int          rv_cnt    [3];
  int          gnt_order [2];
  int          n_gnt;
  logic [2:0]  pend;
  int          sel;
  int          lat;
  bit          seen;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b1, 64'h10,                  64'h1122334455667788, 8'hFF, 2'd2, 64'h0};
    vecs[1] = '{1'b0, 64'h10,                  64'h0,                8'h00, 2'd1, 64'h1122334455667788};
    vecs[2] = '{1'b1, 64'h10,                  64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'd0, 64'h0};
    vecs[3] = '{1'b0, 64'h10,                  64'h0,                8'h00, 2'd1, 64'h11223344AAAAAAAA};
    vecs[4] = '{1'b1, 64'h0,                   64'h0,                8'hFF, 2'd1, 64'h0};
    vecs[5] = '{1'b1, 64'h0,                   64'h5A,               8'h01, 2'd2, 64'h0};
    vecs[6] = '{1'b0, 64'h800,                 64'h0,                8'h00, 2'd0, 64'h5A};
    vecs[7] = '{1'b1, 64'h10,                  64'hFFFFFFFFFFFFFFFF, 8'h00, 2'd2, 64'h0};
    vecs[8] = '{1'b0, 64'hFFFFFFFF00000017,    64'h0,                8'h00, 2'd1, 64'h11223344AAAAAAAA};

    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_size = 0; a_id = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_size = 0; b_id = 0;

    // Reset with requests asserted: nothing may be granted.
    rst = 1;
    repeat (2) @(posedge clk);
    #1 a_req = 1; a_id = 2'd2; b_req = 1; b_id = 2'd1;
    @(negedge clk);
    chk("rst_gnt_l1", {63'd0, a_gnt}, 64'd0);
    chk("rst_gnt_id_l1", {62'd0, a_gnt_id}, 64'd0);
    chk("rst_rvalid_l1", {63'd0, a_rvalid}, 64'd0);
    chk("rst_rdata_l1", a_rdata, 64'd0);
    chk("rst_id_l1", {62'd0, a_id_o}, 64'd0);
    chk("rst_gnt_l4", {63'd0, b_gnt}, 64'd0);
    chk("rst_rvalid_l4", {63'd0, b_rvalid}, 64'd0);
    @(posedge clk);
    #1 rst = 0; a_req = 0; a_id = 0; b_req = 0; b_id = 0;

    // Table-driven single transactions on the LATENCY=1 instance.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      a_req = 1; a_we = vecs[i].we; a_addr = vecs[i].addr; a_wdata = vecs[i].wdata;
      a_be = vecs[i].be; a_id = vecs[i].id; a_size = 2'(i);
      @(negedge clk);
      chk($sformatf("v%0d_idle_rvalid", i), {63'd0, a_rvalid}, 64'd0);
      chk($sformatf("v%0d_idle_rdata", i), a_rdata, 64'd0);
      chk($sformatf("v%0d_gnt", i), {63'd0, a_gnt}, 64'd1);
      chk($sformatf("v%0d_gnt_id", i), {62'd0, a_gnt_id}, {62'd0, vecs[i].id});
      @(posedge clk);
      #1 a_req = 0; a_we = 0;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), {63'd0, a_rvalid}, 64'd1);
      chk($sformatf("v%0d_id_o", i), {62'd0, a_id_o}, {62'd0, vecs[i].id});
      chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].exp);
    end

    // LATENCY=4 with req held: write then read of the same word.
    @(posedge clk);
    #1 b_req = 1; b_we = 1; b_addr = 64'h8; b_wdata = 64'h77; b_be = 8'hFF; b_id = 2'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d_gnt", c), {63'd0, b_gnt}, {63'd0, (c == 0 || c == 5)});
      chk($sformatf("hold_c%0d_rvalid", c), {63'd0, b_rvalid}, {63'd0, (c == 4 || c == 9)});
      if (c == 4) begin
        chk("hold_wr_id", {62'd0, b_id_o}, 64'd1);
        chk("hold_wr_rdata", b_rdata, 64'd0);
      end
      if (c == 9) begin
        chk("hold_rd_id", {62'd0, b_id_o}, 64'd2);
        chk("hold_rd_rdata", b_rdata, 64'h77);
      end
      @(posedge clk);
      #1;
      if (c == 4) begin b_we = 0; b_id = 2'd2; end
      if (c == 5) b_req = 0;
    end

    // Reset two cycles after a write grant: no response, write stays.
    b_req = 1; b_we = 1; b_addr = 64'h20; b_wdata = 64'hDEAD; b_be = 8'hFF; b_id = 2'd1;
    @(negedge clk);
    chk("rstmid_gnt", {63'd0, b_gnt}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_wait_gnt", {63'd0, b_gnt}, 64'd0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rstmid_gnt_in_rst", {63'd0, b_gnt}, 64'd0);
    chk("rstmid_gnt_id_in_rst", {62'd0, b_gnt_id}, 64'd0);
    chk("rstmid_rvalid_in_rst", {63'd0, b_rvalid}, 64'd0);
    chk("rstmid_rdata_in_rst", b_rdata, 64'd0);
    chk("rstmid_id_in_rst", {62'd0, b_id_o}, 64'd0);
    @(posedge clk);
    #1 rst = 0; b_req = 0; b_we = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b_rvalid) seen = 1;
    end
    chk("rstmid_no_rvalid", {63'd0, seen}, 64'd0);
    @(posedge clk);
    #1 b_req = 1; b_we = 0; b_addr = 64'h20; b_id = 2'd2;
    @(negedge clk);
    chk("rstmid_rd_gnt", {63'd0, b_gnt}, 64'd1);
    @(posedge clk);
    #1 b_req = 0;
    lat = 0;
    seen = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (b_rvalid) begin
        seen = 1;
        lat = c;
        chk("rstmid_rd_rdata", b_rdata, 64'hDEAD);
        chk("rstmid_rd_id", {62'd0, b_id_o}, 64'd2);
      end
      if (!seen) @(posedge clk);
    end
    chk("rstmid_rd_latency", 64'(lat), 64'd4);

    // Ports 0 and 2 contend; fixed priority serves port 0 first.
    port_addr[0] = 64'h10;  port_exp[0] = 64'h11223344AAAAAAAA;
    port_addr[1] = 64'h0;   port_exp[1] = 64'h0;
    port_addr[2] = 64'h800; port_exp[2] = 64'h5A;
    rv_cnt[0] = 0; rv_cnt[1] = 0; rv_cnt[2] = 0;
    gnt_order[0] = -1; gnt_order[1] = -1;
    n_gnt = 0;
    pend = 3'b101;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      sel = pend[0] ? 0 : (pend[1] ? 1 : 2);
      a_req = |pend; a_we = 0; a_id = 2'(sel); a_addr = port_addr[sel];
      @(negedge clk);
      if (a_gnt) begin
        if (n_gnt < 2) gnt_order[n_gnt] = int'(a_gnt_id);
        n_gnt++;
        pend[sel] = 1'b0;
      end
      if (a_rvalid) begin
        rv_cnt[a_id_o]++;
        chk($sformatf("arb_rdata_p%0d", a_id_o), a_rdata, port_exp[a_id_o]);
      end
    end
    a_req = 0;
    chk("arb_first", 64'(gnt_order[0]), 64'd0);
    chk("arb_second", 64'(gnt_order[1]), 64'd2);
    chk("arb_rv_p0", 64'(rv_cnt[0]), 64'd1);
    chk("arb_rv_p1", 64'(rv_cnt[1]), 64'd0);
    chk("arb_rv_p2", 64'(rv_cnt[2]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
